// File: rtl/cache_mem_arbiter_pkg.sv
// Constants shared by the cache controller and the cache memory arbiter:
// bus state encoding, block width and access-counter width.
package cache_mem_arbiter_pkg;

    localparam int WORD_W = 10;
    localparam int BLK_W  = 2 * WORD_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin tie-break: a lone request always wins, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    always_comb begin
        any = |req;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one single-port block RAM between two cache requesters; each
// transaction runs IDLE -> ACCESS (RAM_LAT cycles) -> RESP (one-cycle ready).
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int AW      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             rw0,
    input  logic [AW-1:0]    addr0,
    input  logic [BLK_W-1:0] wdata0,
    input  logic             req1,
    input  logic             rw1,
    input  logic [AW-1:0]    addr1,
    input  logic [BLK_W-1:0] wdata1,
    output logic             ready0,
    output logic [BLK_W-1:0] rdata0,
    output logic             ready1,
    output logic [BLK_W-1:0] rdata1,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [BLK_W-1:0] ram_wdata,
    input  logic [BLK_W-1:0] ram_rdata,
    output logic             grant,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_LAT - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             rw_q, rw_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BLK_W-1:0] wdata_q, wdata_d;
    logic [BLK_W-1:0] rdata0_q, rdata0_d;
    logic [BLK_W-1:0] rdata1_q, rdata1_d;

    logic             arb_idx;
    logic             arb_any;
    logic             access_done;

    rr_arb2 u_arb (
        .req     ({req1, req0}),
        .last    (last_q),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign access_done = (state_q == ST_ACCESS) && (cnt_q == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_any) state_d = ST_ACCESS;
            ST_ACCESS: if (access_done) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ram_en = 1'b0;
        ram_we = 1'b0;
        ready0 = 1'b0;
        ready1 = 1'b0;
        busy   = 1'b0;
        grant  = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                ram_en = 1'b1;
                ram_we = rw_q;
                busy   = 1'b1;
                grant  = grant_q;
            end
            ST_RESP: begin
                ready0 = ~grant_q;
                ready1 = grant_q;
                busy   = 1'b1;
                grant  = grant_q;
            end
            default: ;
        endcase
    end

    // The request is latched at grant, so requesters may change or drop
    // their inputs for the rest of the transaction.
    always_comb begin
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    cnt_d   = '0;
                    grant_d = arb_idx;
                    last_d  = arb_idx;
                    rw_d    = arb_idx ? rw1    : rw0;
                    addr_d  = arb_idx ? addr1  : addr0;
                    wdata_d = arb_idx ? wdata1 : wdata0;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (access_done && !rw_q) begin
                    if (grant_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; last-grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a RAM_LAT=3 instance exercised by scenario and
// random tasks, plus a RAM_LAT=1 instance for the single-cycle read case.
module tb_cache_mem_arbiter;

    localparam int LAT = 3;

    logic clk;
    logic rst;

    logic        req0, rw0, req1, rw1;
    logic [9:0]  addr0, addr1;
    logic [19:0] wdata0, wdata1;
    logic        ready0, ready1, ram_en, ram_we, grant, busy;
    logic [19:0] rdata0, rdata1, ram_wdata, ram_rdata;
    logic [9:0]  ram_addr;

    logic        l_req0, l_rw0, l_req1, l_rw1;
    logic [9:0]  l_addr0, l_addr1;
    logic [19:0] l_wdata0, l_wdata1;
    logic        l_ready0, l_ready1, l_ram_en, l_ram_we, l_grant, l_busy;
    logic [19:0] l_rdata0, l_rdata1, l_ram_wdata, l_ram_rdata;
    logic [9:0]  l_ram_addr;

    logic [19:0] mem     [1024];
    logic [19:0] ref_mem [1024];
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [19:0] ld_data;

    logic [19:0] ref_rdata [2];
    logic        model_last;
    int          checks;
    int          errors;

    cache_mem_arbiter #(.RAM_LAT(LAT), .AW(10)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .ready0(ready0), .rdata0(rdata0), .ready1(ready1), .rdata1(rdata1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .grant(grant), .busy(busy)
    );

    cache_mem_arbiter #(.RAM_LAT(1), .AW(10)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req0(l_req0), .rw0(l_rw0), .addr0(l_addr0), .wdata0(l_wdata0),
        .req1(l_req1), .rw1(l_rw1), .addr1(l_addr1), .wdata1(l_wdata1),
        .ready0(l_ready0), .rdata0(l_rdata0), .ready1(l_ready1), .rdata1(l_rdata1),
        .ram_en(l_ram_en), .ram_we(l_ram_we), .ram_addr(l_ram_addr),
        .ram_wdata(l_ram_wdata), .ram_rdata(l_ram_rdata),
        .grant(l_grant), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata   = mem[ram_addr];
    assign l_ram_rdata = mem[l_ram_addr];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else begin
            if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
            if (l_ram_en && l_ram_we) mem[l_ram_addr] <= l_ram_wdata;
        end
    end

    task automatic load(input logic [9:0] a, input logic [19:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // One or two simultaneous requests on the RAM_LAT=3 instance, checked
    // cycle by cycle against the arbitration rule and the fixed latency.
    task automatic run_pair(input logic e0, input logic e1,
                            input logic r0, input logic [9:0] a0, input logic [19:0] w0,
                            input logic r1, input logic [9:0] a1, input logic [19:0] w1,
                            input string tag);
        logic        rwv [2];
        logic [9:0]  av  [2];
        logic [19:0] wv  [2];
        int          t_exp [2];
        int          first, second, own, own_i, lim, who;
        logic        both, acc, exp_b;
        rwv[0] = r0; av[0] = a0; wv[0] = w0;
        rwv[1] = r1; av[1] = a1; wv[1] = w1;
        both   = e0 && e1;
        first  = both ? (model_last ? 0 : 1) : (e1 ? 1 : 0);
        second = 1 - first;
        t_exp[0] = -1; t_exp[1] = -1;
        t_exp[first] = LAT + 1;
        if (both) t_exp[second] = 2 * LAT + 3;
        lim = (both ? 2 * LAT + 3 : LAT + 1) + 1;
        who = first;
        for (int k = 0; k < (both ? 2 : 1); k++) begin
            who = (k == 0) ? first : second;
            if (rwv[who]) ref_mem[av[who]] = wv[who];
            else ref_rdata[who] = ref_mem[av[who]];
            model_last = who[0];
        end
        req0 = e0; rw0 = r0; addr0 = a0; wdata0 = w0;
        req1 = e1; rw1 = r1; addr1 = a1; wdata1 = w1;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            own = -1;
            if (c <= LAT + 1) own = first;
            else if (both && c >= LAT + 3 && c <= 2 * LAT + 3) own = second;
            own_i = (own < 0) ? 0 : own;
            acc = (c <= LAT) || (both && c >= LAT + 3 && c <= 2 * LAT + 2);
            checks++;
            if (ram_en !== acc) begin
                errors++; $display("FAIL %s ram_en cyc %0d got %b exp %b", tag, c, ram_en, acc);
            end
            exp_b = acc ? rwv[own_i] : 1'b0;
            checks++;
            if (ram_we !== exp_b) begin
                errors++; $display("FAIL %s ram_we cyc %0d got %b exp %b", tag, c, ram_we, exp_b);
            end
            exp_b = (own >= 0);
            checks++;
            if (busy !== exp_b) begin
                errors++; $display("FAIL %s busy cyc %0d got %b exp %b", tag, c, busy, exp_b);
            end
            exp_b = (own == 1);
            checks++;
            if (grant !== exp_b) begin
                errors++; $display("FAIL %s grant cyc %0d got %b exp %b", tag, c, grant, exp_b);
            end
            exp_b = (c == t_exp[0]);
            checks++;
            if (ready0 !== exp_b) begin
                errors++; $display("FAIL %s ready0 cyc %0d got %b exp %b", tag, c, ready0, exp_b);
            end
            exp_b = (c == t_exp[1]);
            checks++;
            if (ready1 !== exp_b) begin
                errors++; $display("FAIL %s ready1 cyc %0d got %b exp %b", tag, c, ready1, exp_b);
            end
            if (acc) begin
                checks++;
                if (ram_addr !== av[own_i] || ram_wdata !== wv[own_i]) begin
                    errors++;
                    $display("FAIL %s ram_addr/wdata cyc %0d got %h/%h exp %h/%h",
                             tag, c, ram_addr, ram_wdata, av[own_i], wv[own_i]);
                end
            end
            if (ready0) req0 = 1'b0;
            if (ready1) req1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (rdata0 !== ref_rdata[0]) begin
            errors++; $display("FAIL %s rdata0 got %h exp %h", tag, rdata0, ref_rdata[0]);
        end
        checks++;
        if (rdata1 !== ref_rdata[1]) begin
            errors++; $display("FAIL %s rdata1 got %h exp %h", tag, rdata1, ref_rdata[1]);
        end
        checks++;
        if (ram_addr !== av[who]) begin
            errors++; $display("FAIL %s ram_addr_hold got %h exp %h", tag, ram_addr, av[who]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 10'(i); ld_data = 20'($urandom);
            ref_mem[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
        checks++;
        if ({ready0, ready1, ram_en, ram_we, grant, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 000000", {ready0, ready1, ram_en, ram_we, grant, busy});
        end
        checks++;
        if (rdata0 !== 20'h0 || rdata1 !== 20'h0 || ram_addr !== 10'h0 || ram_wdata !== 20'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h exp zeros", rdata0, rdata1, ram_addr, ram_wdata);
        end
        checks++;
        if ({l_ready0, l_ready1, l_ram_en, l_ram_we, l_grant, l_busy} !== 6'b0 || l_rdata0 !== 20'h0) begin
            errors++; $display("FAIL reset_l1 got %b %h exp zeros", {l_ready0, l_ready1, l_ram_en, l_busy}, l_rdata0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle busy %b ram_en %b exp 0 0", busy, ram_en);
        end
        model_last = 1'b1;
        ref_rdata[0] = 20'h0; ref_rdata[1] = 20'h0;
    endtask

    task automatic test_tie();
        run_pair(1'b1, 1'b1, 1'b0, 10'h010, 20'($urandom), 1'b0, 10'h020, 20'($urandom), "tie");
    endtask

    task automatic test_fairness();
        int   who, k;
        logic exp0, exp1;
        k = 0;
        rw0 = 1'b0; rw1 = 1'b0;
        addr0 = 10'($urandom_range(0, 1023));
        addr1 = 10'($urandom_range(0, 1023));
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 4 * (LAT + 2); c++) begin
            @(negedge clk);
            if ((c % (LAT + 2)) == LAT + 1) begin
                who = model_last ? 0 : 1;
                model_last = who[0];
                ref_rdata[who] = ref_mem[(who == 1) ? addr1 : addr0];
                exp0 = (who == 0); exp1 = (who == 1);
                checks++;
                if (ready0 !== exp0 || ready1 !== exp1) begin
                    errors++; $display("FAIL fair_order txn %0d got %b%b exp %b%b", k, ready1, ready0, exp1, exp0);
                end
                checks++;
                if (rdata0 !== ref_rdata[0] || rdata1 !== ref_rdata[1]) begin
                    errors++; $display("FAIL fair_rdata txn %0d got %h %h exp %h %h", k, rdata0, rdata1, ref_rdata[0], ref_rdata[1]);
                end
                if (who == 0) addr0 = 10'($urandom_range(0, 1023));
                else addr1 = 10'($urandom_range(0, 1023));
                k++;
                if (k == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end else begin
                checks++;
                if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
                    errors++; $display("FAIL fair_spurious cyc %0d got %b%b exp 00", c, ready1, ready0);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL fair_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_write();
        run_pair(1'b0, 1'b1, 1'b0, 10'h000, 20'h0, 1'b1, 10'h046, 20'h00309, "write1");
        run_pair(1'b1, 1'b0, 1'b0, 10'h046, 20'h0, 1'b0, 10'h000, 20'h0, "readback");
    endtask

    task automatic test_drop();
        logic [9:0] a;
        logic       exp_b;
        a = 10'h155;
        req1 = 1'b0;
        req0 = 1'b1; rw0 = 1'b0; addr0 = a; wdata0 = 20'h0;
        model_last = 1'b0;
        ref_rdata[0] = ref_mem[a];
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req0 = 1'b0; rw0 = 1'b1; addr0 = ~a;
            end
            exp_b = (c <= LAT);
            checks++;
            if (ram_en !== exp_b || ram_we !== 1'b0) begin
                errors++; $display("FAIL drop_ram cyc %0d got en %b we %b exp en %b we 0", c, ram_en, ram_we, exp_b);
            end
            if (c <= LAT) begin
                checks++;
                if (ram_addr !== a) begin
                    errors++; $display("FAIL drop_addr cyc %0d got %h exp %h", c, ram_addr, a);
                end
            end
            exp_b = (c == LAT + 1);
            checks++;
            if (ready0 !== exp_b) begin
                errors++; $display("FAIL drop_ready0 cyc %0d got %b exp %b", c, ready0, exp_b);
            end
        end
        checks++;
        if (rdata0 !== ref_rdata[0] || busy !== 1'b0) begin
            errors++; $display("FAIL drop_end rdata0 %h busy %b exp %h 0", rdata0, busy, ref_rdata[0]);
        end
    endtask

    task automatic test_lat1();
        logic exp_b;
        load(10'h032, 20'h12345);
        l_req0 = 1'b1; l_rw0 = 1'b0; l_addr0 = 10'h032; l_wdata0 = 20'h0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            exp_b = (c == 1);
            checks++;
            if (l_ram_en !== exp_b) begin
                errors++; $display("FAIL lat1_ram_en cyc %0d got %b exp %b", c, l_ram_en, exp_b);
            end
            if (c == 1) begin
                checks++;
                if (l_ram_addr !== 10'h032) begin
                    errors++; $display("FAIL lat1_addr got %h exp 032", l_ram_addr);
                end
            end
            exp_b = (c == 2);
            checks++;
            if (l_ready0 !== exp_b) begin
                errors++; $display("FAIL lat1_ready0 cyc %0d got %b exp %b", c, l_ready0, exp_b);
            end
            if (c == 2) begin
                checks++;
                if (l_rdata0 !== 20'h12345) begin
                    errors++; $display("FAIL lat1_rdata0 got %h exp 12345", l_rdata0);
                end
            end
            if (l_ready0) l_req0 = 1'b0;
        end
        l_req0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        req1 = 1'b0;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 10'h0aa; wdata0 = 20'h0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre ram_en got %b exp 1", ram_en);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ram_en !== 1'b0 || busy !== 1'b0 || grant !== 1'b0 || ready0 !== 1'b0) begin
            errors++; $display("FAIL rstmid_async en %b busy %b grant %b ready0 %b exp 0000", ram_en, busy, grant, ready0);
        end
        checks++;
        if (rdata0 !== 20'h0 || rdata1 !== 20'h0 || ram_addr !== 10'h0) begin
            errors++; $display("FAIL rstmid_data got %h %h %h exp zeros", rdata0, rdata1, ram_addr);
        end
        req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
                errors++; $display("FAIL rstmid_ready cyc %0d got %b%b exp 00", c, ready1, ready0);
            end
        end
        rst = 1'b0;
        model_last = 1'b1;
        ref_rdata[0] = 20'h0; ref_rdata[1] = 20'h0;
        @(negedge clk);
        run_pair(1'b1, 1'b0, 1'b0, 10'h0aa, 20'h0, 1'b0, 10'h0, 20'h0, "after_rst");
    endtask

    task automatic test_random();
        int pat;
        for (int n = 0; n < 24; n++) begin
            pat = $urandom_range(1, 3);
            run_pair(pat[0], pat[1],
                     1'($urandom), 10'($urandom_range(0, 31)), 20'($urandom),
                     1'($urandom), 10'($urandom_range(0, 31)), 20'($urandom),
                     "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
        l_req0 = 1'b0; l_rw0 = 1'b0; l_addr0 = '0; l_wdata0 = '0;
        l_req1 = 1'b0; l_rw1 = 1'b0; l_addr1 = '0; l_wdata1 = '0;
        model_last = 1'b1;
        ref_rdata[0] = 20'h0; ref_rdata[1] = 20'h0;
        rst = 1'b1;
        test_reset();
        test_tie();
        test_fairness();
        test_write();
        test_drop();
        test_lat1();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter RAM_LAT, default 1: RAM access cycles per transaction, legal range 1..15.
REQ-002 Parameter AW, default 10: word-address width shared by requesters and RAM.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset rst, asynchronous, active-high; clock clk.
REQ-005 reqN (N=0,1)  in  1  requester N access request; held high until readyN.
REQ-006 rwN  in  1  requester N direction; 0 = read, 1 = write.
REQ-007 addrN  in  AW  requester N block address.
REQ-008 wdataN  in  20  requester N write block (two 10-bit words).
REQ-009 readyN  out  1  one-cycle completion pulse to requester N.
REQ-010 rdataN  out  20  requester N read block; valid while readyN is high, then held.
REQ-011 ram_en  out  1  RAM access strobe.
REQ-012 ram_we  out  1  RAM write enable; 1 only while ram_en = 1.
REQ-013 ram_addr  out  AW  RAM address.
REQ-014 ram_wdata  out  20  RAM write data.
REQ-015 ram_rdata  in  20  RAM read data; valid in the last cycle of an access.
REQ-016 grant  out  1  index of the requester currently owning the RAM; 0 when idle.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and RESP; no other states are reachable.
REQ-019 IDLE: with any reqN high, arbitrate, latch the winner's rw/addr/wdata, load cnt = 0, and go to ACCESS at the next edge.
REQ-020 Arbitration: single request wins; when both are high, the requester NOT granted last wins; last-grant pointer updates on every grant.
REQ-021 ACCESS: ram_en = 1, ram_we = latched rw, ram_addr/ram_wdata = latched values; cnt increments every cycle; leave for RESP when cnt = RAM_LAT-1.
REQ-022 On the ACCESS-to-RESP edge, ram_rdata is captured into the granted requester's rdata register on reads only; the other rdata is untouched.
REQ-023 RESP: ready[grant] = 1 for exactly one cycle; then return to IDLE.
REQ-024 Latency: req seen in IDLE at cycle 0 gives ACCESS in cycles 1..RAM_LAT and readyN in cycle RAM_LAT+1.
REQ-025 Outside ACCESS: ram_en = 0 and ram_we = 0; ram_addr/ram_wdata hold the last latched values.
REQ-026 A reqN dropped mid-transaction does not abort it; the transaction completes and readyN still pulses.
REQ-027 The losing requester's req stays pending and is granted in the next IDLE cycle. It waits at most one transaction.
REQ-028 Request inputs are sampled only in IDLE; changes to addr/rw/wdata after the grant have no effect.
REQ-029 The bus returns to IDLE for exactly one cycle between transactions. Back-to-back throughput is one transaction per RAM_LAT+2 cycles.

Reset
REQ-030 rst high SHALL immediately force IDLE, cnt = 0, last-grant = 1 (requester 0 wins first tie), ram_en = ram_we = 0, ready0 = ready1 = 0, grant = 0, busy = 0, and rdata0 = rdata1 = ram_addr = ram_wdata = 0.
REQ-031 Reset mid-ACCESS or mid-RESP SHALL drop the transaction without a readyN pulse. After rst is released, the FSM starts in IDLE.

Structure
REQ-032 State encoding (IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10) and the 20-bit block width constant SHALL live in the shared cache package, with the cache controller using the same constants.
REQ-033 Tie-break logic SHALL be a sub-module rr_arb2 (req[1:0], last, gnt_idx, any). The rest of the block is flat.

Verification
REQ-034 RAM_LAT=1: req0 read, addr0=0x032, RAM holds 0x12345 -> ram_en high in cycle 1, ready0 pulses in cycle 2, rdata0 = 0x12345.
REQ-035 req0 and req1 raised in the same cycle after reset -> requester 0 served first, then requester 1. ready1 comes exactly RAM_LAT+2 cycles after ready0.
REQ-036 Both requesters held high for 4 transactions -> grant order 0,1,0,1; no requester starves.
REQ-037 req1 write, addr1=0x046, wdata1=0x00309, RAM_LAT=3 -> ram_we high for exactly 3 cycles with those values, ready1 in cycle 4, rdata1 unchanged.
REQ-038 rst asserted in the 2nd ACCESS cycle (RAM_LAT=3) -> ram_en falls without a clock edge, no readyN pulse occurs, and the next req is accepted from IDLE.
REQ-039 req0 dropped in cycle 1 of a read -> ready0 still pulses in cycle RAM_LAT+1 and the FSM returns to IDLE.
